// File: rtl/bcd_chain_counter_if.sv
// Control/data bundle for the BCD digit chain: count controls, load/limit
// vectors and the digit outputs with their status flags.
interface bcd_chain_counter_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  en;
    logic                  dir;
    logic                  clear;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   limit;
    logic [4*DIGITS-1:0]   q;
    logic                  wrap;
    logic                  zero;

    modport master (
        output en, dir, clear, load, load_val, limit,
        input  q, wrap, zero
    );

    modport slave (
        input  en, dir, clear, load, load_val, limit,
        output q, wrap, zero
    );
endinterface

// File: rtl/bcd_chain_counter.sv
// Cascade of BCD digit counters with per-digit limits, up/down counting,
// synchronous clear and parallel load. Carry/borrow ripples through all
// digits within a single cycle.
module bcd_chain_counter #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_h,
    bcd_chain_counter_if.slave    bus
);

    logic [4*DIGITS-1:0] q_q;
    logic [4*DIGITS-1:0] q_d;
    logic [DIGITS:0]     step;
    logic [DIGITS-1:0]   term;

    // Digit register; asynchronous reset clears the whole chain.
    always_ff @(posedge clk or posedge rst_h) begin
        if (rst_h) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    // Step-enable ripple and next-digit values; clear/load override stepping.
    always_comb begin
        logic [3:0] dig;
        logic [3:0] lim;
        q_d     = q_q;
        step    = '0;
        term    = '0;
        dig     = '0;
        lim     = '0;
        step[0] = bus.en;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            dig       = q_q[4*i +: 4];
            lim       = bus.limit[4*i +: 4];
            term[i]   = bus.dir ? (dig == 4'd0) : (dig >= lim);
            step[i+1] = step[i] & term[i];
            if (step[i]) begin
                if (bus.dir) begin
                    q_d[4*i +: 4] = term[i] ? lim : (dig - 4'd1);
                end else begin
                    q_d[4*i +: 4] = term[i] ? 4'd0 : (dig + 4'd1);
                end
            end
        end
        if (bus.clear) begin
            q_d = '0;
        end else if (bus.load) begin
            q_d = bus.load_val;
        end
    end

    // step[DIGITS] is step[DIGITS-1] & term[DIGITS-1]: the whole chain turns over.
    assign bus.wrap = bus.en & ~bus.clear & ~bus.load & step[DIGITS];
    assign bus.zero = (q_q == '0);
    assign bus.q    = q_q;

endmodule

// File: tb/tb_bcd_chain_counter.sv
// Scoreboard bench for bcd_chain_counter: a 4-digit and a 1-digit instance.
module tb_bcd_chain_counter;

    logic clk;
    logic rst_h;
    int   n_checks;
    int   n_fail;
    logic [15:0] exp_q4[$];
    logic [3:0]  exp_q1[$];
    logic [15:0] model_q;

    bcd_chain_counter_if #(.DIGITS(4)) b4 ();
    bcd_chain_counter_if #(.DIGITS(1)) b1 ();

    bcd_chain_counter #(.DIGITS(4)) dut4 (.clk(clk), .rst_h(rst_h), .bus(b4));
    bcd_chain_counter #(.DIGITS(1)) dut1 (.clk(clk), .rst_h(rst_h), .bus(b1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference next-state of a 4-digit chain, digit by digit with explicit carry.
    function automatic logic [15:0] model_next(input logic [15:0] cur, input logic [15:0] lim,
                                               input logic [15:0] lv, input logic e, input logic d,
                                               input logic c, input logic l, output logic w);
        logic [15:0] r;
        logic        carry;
        logic [3:0]  dg;
        logic [3:0]  lm;
        r = cur;
        w = 1'b0;
        if (c) return 16'h0000;
        if (l) return lv;
        if (!e) return cur;
        carry = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (carry) begin
                dg = cur[k*4 +: 4];
                lm = lim[k*4 +: 4];
                if (!d) begin
                    if (dg >= lm) r[k*4 +: 4] = 4'h0;
                    else begin r[k*4 +: 4] = dg + 4'h1; carry = 1'b0; end
                end else begin
                    if (dg == 4'h0) r[k*4 +: 4] = lm;
                    else begin r[k*4 +: 4] = dg - 4'h1; carry = 1'b0; end
                end
            end
        end
        w = carry;
        return r;
    endfunction

    task automatic apply4(input string tag, input logic e, input logic d, input logic c,
                          input logic l, input logic [15:0] lv, input logic [15:0] lim,
                          input logic [15:0] exp_q, input logic exp_w);
        logic [15:0] want;
        @(negedge clk);
        b4.en = e; b4.dir = d; b4.clear = c; b4.load = l;
        b4.load_val = lv; b4.limit = lim;
        #1;
        check_eq({tag, "_wrap"}, {31'd0, b4.wrap}, {31'd0, exp_w});
        exp_q4.push_back(exp_q);
        @(posedge clk);
        #1;
        want = exp_q4.pop_front();
        check_eq({tag, "_q"}, {16'd0, b4.q}, {16'd0, want});
        check_eq({tag, "_zero"}, {31'd0, b4.zero}, {31'd0, (want == 16'h0)});
    endtask

    task automatic apply1(input string tag, input logic e, input logic d, input logic l,
                          input logic [3:0] lv, input logic [3:0] lim,
                          input logic [3:0] exp_q, input logic exp_w);
        @(negedge clk);
        b1.en = e; b1.dir = d; b1.clear = 1'b0; b1.load = l;
        b1.load_val = lv; b1.limit = lim;
        #1;
        check_eq({tag, "_wrap"}, {31'd0, b1.wrap}, {31'd0, exp_w});
        exp_q1.push_back(exp_q);
        @(posedge clk);
        #1;
        check_eq({tag, "_q"}, {28'd0, b1.q}, {28'd0, exp_q1.pop_front()});
    endtask

    initial begin
        logic        w;
        logic        e, d, c, l;
        logic [15:0] lv, lim, nq;
        n_checks = 0;
        n_fail   = 0;
        rst_h = 1'b1;
        b4.en = 1'b0; b4.dir = 1'b0; b4.clear = 1'b0; b4.load = 1'b0;
        b4.load_val = 16'h0; b4.limit = 16'h9999;
        b1.en = 1'b0; b1.dir = 1'b0; b1.clear = 1'b0; b1.load = 1'b0;
        b1.load_val = 4'h0; b1.limit = 4'h9;
        #2;
        check_eq("rst_q", {16'd0, b4.q}, 32'h0);
        check_eq("rst_zero", {31'd0, b4.zero}, 32'd1);
        check_eq("rst_wrap", {31'd0, b4.wrap}, 32'd0);
        @(negedge clk);
        rst_h = 1'b0;

        // Reset mid-count
        apply4("ld1234", 0, 0, 0, 1, 16'h1234, 16'h9999, 16'h1234, 0);
        apply4("up1235", 1, 0, 0, 0, 16'h0000, 16'h9999, 16'h1235, 0);
        @(negedge clk);
        #2 rst_h = 1'b1;
        #1;
        check_eq("arst_q", {16'd0, b4.q}, 32'h0);
        check_eq("arst_zero", {31'd0, b4.zero}, 32'd1);
        b4.dir = 1'b1;
        #1;
        check_eq("arst_wrap_dn", {31'd0, b4.wrap}, 32'd1);
        b4.dir = 1'b0;
        #1;
        check_eq("arst_wrap_up", {31'd0, b4.wrap}, 32'd0);
        b4.en = 1'b0;
        @(posedge clk);
        #1;
        check_eq("arst_hold", {16'd0, b4.q}, 32'h0);
        @(negedge clk);
        rst_h = 1'b0;
        apply4("post_rst", 0, 0, 0, 0, 16'h0000, 16'h9999, 16'h0000, 0);

        // MM:SS up cascade
        apply4("mmss_ld", 0, 0, 0, 1, 16'h5958, 16'h5959, 16'h5958, 0);
        apply4("mmss_u1", 1, 0, 0, 0, 16'h0000, 16'h5959, 16'h5959, 0);
        apply4("mmss_wr", 1, 0, 0, 0, 16'h0000, 16'h5959, 16'h0000, 1);
        apply4("mmss_u2", 1, 0, 0, 0, 16'h0000, 16'h5959, 16'h0001, 0);

        // Down cascade
        apply4("dn_ld", 0, 1, 0, 1, 16'h0100, 16'h5959, 16'h0100, 0);
        apply4("dn_brw", 1, 1, 0, 0, 16'h0000, 16'h5959, 16'h0059, 0);
        apply4("dn_ld0", 1, 1, 0, 1, 16'h0000, 16'h5959, 16'h0000, 0);
        apply4("dn_wr", 1, 1, 0, 0, 16'h0000, 16'h5959, 16'h5959, 1);

        // Priority clear > load > en
        apply4("pri_clr", 1, 0, 1, 1, 16'h4321, 16'h9999, 16'h0000, 0);
        apply4("pri_ld", 1, 0, 0, 1, 16'h4321, 16'h9999, 16'h4321, 0);
        apply4("hold", 0, 0, 0, 0, 16'h0000, 16'h9999, 16'h4321, 0);

        // Out-of-range digit, lowered limit, binary limit above 9
        apply4("oor_ld", 0, 0, 0, 1, 16'h000C, 16'h9999, 16'h000C, 0);
        apply4("oor_up", 1, 0, 0, 0, 16'h0000, 16'h9999, 16'h0010, 0);
        apply4("lim_ld", 0, 0, 0, 1, 16'h0005, 16'h9999, 16'h0005, 0);
        apply4("lim_low", 1, 0, 0, 0, 16'h0000, 16'h9993, 16'h0010, 0);
        apply4("hex_ld", 0, 0, 0, 1, 16'h000E, 16'h999F, 16'h000E, 0);
        apply4("hex_up", 1, 0, 0, 0, 16'h0000, 16'h999F, 16'h000F, 0);
        apply4("hex_wr", 1, 0, 0, 0, 16'h0000, 16'h999F, 16'h0010, 0);

        // Single-digit instance, direction toggled every cycle
        b4.en = 1'b0;
        apply1("d1_ld", 0, 0, 1, 4'h9, 4'h9, 4'h9, 0);
        for (int unsigned i = 0; i < 3; i++) begin
            apply1("d1_up", 1, 0, 0, 4'h0, 4'h9, 4'h0, 1);
            apply1("d1_dn", 1, 1, 0, 4'h0, 4'h9, 4'h9, 1);
        end

        // Randomised run against the reference model
        apply4("rnd_clr", 0, 0, 1, 0, 16'h0000, 16'h9999, 16'h0000, 0);
        model_q = 16'h0000;
        for (int unsigned i = 0; i < 200; i++) begin
            c   = ($urandom_range(0, 19) == 0);
            l   = ($urandom_range(0, 9) == 0);
            e   = ($urandom_range(0, 9) < 8);
            d   = $urandom_range(0, 1) == 1;
            lv  = 16'($urandom);
            lim = (i < 100) ? 16'h5959 : 16'($urandom);
            nq  = model_next(model_q, lim, lv, e, d, c, l, w);
            apply4("rnd", e, d, c, l, lv, lim, nq, w);
            model_q = nq;
        end

        check_eq("sb_empty", exp_q4.size() + exp_q1.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
